usb2_ep_rd_stream: RTL and testbench
====================================

# usb2_ep_rd_stream

Packet reader for the USB 2.0 endpoint buffer. On a start request it fetches a byte run from the endpoint RAM's read port, which has a registered address and returns data one cycle after the address is captured. It presents the bytes as a valid/ready stream to the transmit protocol layer at up to one byte per clock, with backpressure. It sits between the endpoint RAM read port and the packet transmitter, in the PHY clock domain.

## Interface
- `LEN_W`, 11: length width; legal lengths are 0..1024.
- `ADR_W`, 10: RAM address width.
- `phy_clk` in 1: clock; also drives the RAM read port (`rd_clk`).
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; ignored while `busy`.
- `base_adr` in ADR_W: first RAM address; sampled with `start`.
- `length` in LEN_W: payload byte count; sampled with `start`.
- `abort` in 1: terminate the current transfer.
- `rd_adr` out ADR_W: RAM read address.
- `rd_dat_r` in 8: RAM read data, valid the cycle after `rd_adr` is captured by the RAM.
- `out_data` out 8: stream byte.
- `out_valid` out 1: `out_data` is valid.
- `out_last` out 1: final byte of the packet; qualified by `out_valid`.
- `out_ready` in 1: sink accepts; a transfer occurs when `out_valid` and `out_ready` are both high.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse when the transfer completes or is aborted.

## Operation
- **States:** IDLE, STREAM, CRC_LO, CRC_HI, DONE. CRC_LO and CRC_HI exist only under the macro.
- **IDLE, `start` high:**
  - Latch `base_adr` and `length`.
  - `rd_adr <= base_adr`; fetch counter 0; sent counter 0; go to STREAM.
- **STREAM, fetch side:**
  - A 2-entry output FIFO (output register plus skid register) receives RAM data.
  - Issue the next address (`rd_adr <= rd_adr + 1`) only when fetches remaining > 0 and (occupancy + in-flight) < 2.
- **STREAM, address and ordering:**
  - Address arithmetic is modulo 2^ADR_W; 0x3FF wraps to 0x000.
  - Byte order equals address order, with no duplicates or drops under any `out_ready` pattern.
- **STREAM, exit:**
  - `out_last` is asserted on payload byte `length-1`, unless CRC is enabled.
  - When the last byte is accepted, go to DONE, or to CRC_LO if CRC is enabled.
- **`length == 0`:**
  - Without CRC: no bytes are output; STREAM goes to DONE the next cycle.
  - With CRC: go directly to CRC_LO.
- **DONE:** `done = 1` for one cycle; then IDLE.
- **`abort` (any non-IDLE state):**
  - `out_valid` drops the next cycle and the FIFO is flushed.
  - The next state is DONE; `done` pulses once.
  - `abort` in IDLE is ignored.
- **`start` while `busy`:** ignored, with no effect on the running transfer.
- **`start` in the DONE cycle:** ignored.

## Timing
- **Reset values:** `rd_adr`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, state IDLE, FIFO empty.
- **Start latency:** with `start` sampled at edge E0, `rd_adr`=base after E0, the RAM captures it at E1, data is registered at E2, and `out_valid` is high after E2. Latency is 2 clocks.
- **Throughput:** with `out_ready` held high, one byte per clock. An N-byte payload without CRC occupies N+2 busy cycles before DONE.
- **Busy:** `busy` is high from the cycle after `start` through the cycle before DONE returns to IDLE.
- **Stall:** once `out_valid` is asserted, `out_data` and `out_last` are held stable until accepted.

## Configuration
- **`USB2_EP_RD_CRC16_EN` defined:**
  - CRC16 is computed over the accepted payload bytes: poly 0x8005 reflected, init 0xFFFF, output inverted, LSB-first.
  - Two bytes are appended, low byte in CRC_LO and high byte in CRC_HI.
  - `out_last` is asserted on the CRC high byte only.
  - The CRC bytes obey the same handshake.
- **Undefined:** payload only; CRC logic and states are absent.

## Structure
- **Shared package `usb2_ep_pkg`:**
  - State encoding.
  - `USB2_CRC16_POLY` (0xA001 reflected).
  - `USB2_CRC16_INIT` (0xFFFF).
  - `USB2_EP_MAX_LEN` (1024).
- **Sub-module `usb2_crc16_byte`:** combinational next-CRC from (crc, byte). It is reusable by the receive-side checker.

## Test plan
- **Basic read:** RAM[0x010..0x013]=11 22 33 44, `start` with base 0x010 len 4, `out_ready`=1 → bytes 11 22 33 44 on consecutive cycles. `out_valid` appears 2 clocks after `start`; `out_last` on 44; one `done` pulse.
- **Wrap-around:** base 0x3FE, len 4 → addresses 0x3FE 0x3FF 0x000 0x001 are read in order.
- **Backpressure:** random 50% `out_ready` over a 64-byte transfer → exact 64-byte sequence with no drops or duplicates, and `out_data` stable while stalled.
- **Zero-length:** len 0 → without CRC, no `out_valid` and `done` 2 clocks after `start`. With CRC, bytes 00 00 with `out_last` on the second.
- **CRC check value (macro on):** payload ASCII "123456789" → payload followed by C8 B4.
- **Abort and restart:** `abort` mid-transfer after 3 of 10 bytes → `out_valid` low next cycle and one `done` pulse. A new `start` then reads correctly from its own base.

Source files
------------

// File: rtl/usb2_ep_rd_stream_pkg.sv
// Shared definitions for the USB 2.0 endpoint buffer readers/checkers.
// CRC states exist only when USB2_EP_RD_CRC16_EN is defined.
package usb2_ep_pkg;

  localparam logic [15:0] USB2_CRC16_POLY = 16'hA001;
  localparam logic [15:0] USB2_CRC16_INIT = 16'hFFFF;
  localparam int          USB2_EP_MAX_LEN = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
`ifdef USB2_EP_RD_CRC16_EN
    ST_CRC_LO = 3'd2,
    ST_CRC_HI = 3'd3,
`endif
    ST_DONE   = 3'd4
  } ep_rd_state_e;

endpackage

// File: rtl/usb2_crc16_byte.sv
// Combinational CRC16 (reflected 0x8005) byte step, shared with the receive checker.
// Present only when USB2_EP_RD_CRC16_EN is defined.
`ifdef USB2_EP_RD_CRC16_EN
module usb2_crc16_byte
  import usb2_ep_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_dat,
  output logic [15:0] o_crc
);

  logic [15:0] w_c;

  always_comb begin
    w_c = i_crc ^ {8'h00, i_dat};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ USB2_CRC16_POLY) : (w_c >> 1);
    end
    o_crc = w_c;
  end

endmodule
`endif

// File: rtl/usb2_ep_rd_stream.sv
// Endpoint RAM packet reader: registered-address RAM fetch into a 2-entry skid FIFO,
// presented as a valid/ready byte stream. Optional CRC16 trailer under USB2_EP_RD_CRC16_EN.
module usb2_ep_rd_stream
  import usb2_ep_pkg::*;
#(
  parameter int LEN_W = 11,
  parameter int ADR_W = 10
)(
  input  logic             phy_clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [LEN_W-1:0] length,
  input  logic             abort,
  output logic [ADR_W-1:0] rd_adr,
  input  logic [7:0]       rd_dat_r,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  ep_rd_state_e     r_state, w_nxt;
  logic [LEN_W-1:0] r_len, r_fetch_cnt, r_sent_cnt;
  logic [ADR_W-1:0] r_adr;
  logic             r_rd_pend;
  logic [7:0]       r_out_dat, r_skd_dat;
  logic             r_out_vld, r_skd_vld;

  logic       w_stream, w_pop, w_fetch_rem, w_room, w_commit;
  logic       w_last_pay, w_pay_done, w_out_free;
  logic [1:0] w_load;

  assign w_stream    = (r_state == ST_STREAM);
  assign w_pop       = w_stream & r_out_vld & out_ready;
  assign w_fetch_rem = (r_fetch_cnt != r_len);
  // Bytes held or landing next edge; a same-cycle pop frees one slot.
  assign w_load      = {1'b0, r_out_vld} + {1'b0, r_skd_vld} + {1'b0, r_rd_pend};
  assign w_room      = (w_load < 2'd2) || ((w_load == 2'd2) && w_pop);
  assign w_commit    = w_stream & w_fetch_rem & w_room & ~abort;
  assign w_last_pay  = (r_sent_cnt == (r_len - LEN_W'(1)));
  assign w_pay_done  = w_pop & w_last_pay;
  assign w_out_free  = ~r_out_vld | w_pop;
  assign rd_adr      = r_adr;

`ifdef USB2_EP_RD_CRC16_EN
  logic [15:0] r_crc, w_crc_nxt, w_crc_out;

  usb2_crc16_byte u_crc (
    .i_crc (r_crc),
    .i_dat (r_out_dat),
    .o_crc (w_crc_nxt)
  );

  assign w_crc_out = ~r_crc;

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n)                      r_crc <= USB2_CRC16_INIT;
    else if (r_state == ST_IDLE && start) r_crc <= USB2_CRC16_INIT;
    else if (w_pop)                    r_crc <= w_crc_nxt;
  end
`endif

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_nxt = ST_STREAM;
      ST_STREAM: begin
        if (abort) w_nxt = ST_DONE;
        else if ((r_len == '0) || w_pay_done)
`ifdef USB2_EP_RD_CRC16_EN
          w_nxt = ST_CRC_LO;
`else
          w_nxt = ST_DONE;
`endif
      end
`ifdef USB2_EP_RD_CRC16_EN
      ST_CRC_LO: begin
        if (abort)          w_nxt = ST_DONE;
        else if (out_ready) w_nxt = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        if (abort)          w_nxt = ST_DONE;
        else if (out_ready) w_nxt = ST_DONE;
      end
`endif
      ST_DONE:   w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_data  = r_out_dat;
    out_valid = w_stream & r_out_vld;
    out_last  = 1'b0;
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_DONE);
`ifdef USB2_EP_RD_CRC16_EN
    if (r_state == ST_CRC_LO) begin
      out_data  = w_crc_out[7:0];
      out_valid = 1'b1;
    end else if (r_state == ST_CRC_HI) begin
      out_data  = w_crc_out[15:8];
      out_valid = 1'b1;
      out_last  = 1'b1;
    end
`else
    out_last = w_stream & r_out_vld & w_last_pay;
`endif
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len       <= '0;
      r_adr       <= '0;
      r_fetch_cnt <= '0;
      r_sent_cnt  <= '0;
      r_rd_pend   <= 1'b0;
      r_out_dat   <= '0;
      r_out_vld   <= 1'b0;
      r_skd_dat   <= '0;
      r_skd_vld   <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_len       <= length;
      r_adr       <= base_adr;
      r_fetch_cnt <= '0;
      r_sent_cnt  <= '0;
      r_rd_pend   <= 1'b0;
      r_out_vld   <= 1'b0;
      r_skd_vld   <= 1'b0;
    end else if (abort && r_state != ST_IDLE) begin
      r_rd_pend <= 1'b0;
      r_out_vld <= 1'b0;
      r_skd_vld <= 1'b0;
    end else begin
      // rd_adr is captured by the RAM every edge; only committed captures land in the FIFO.
      r_rd_pend <= w_commit;
      if (w_commit) begin
        r_adr       <= r_adr + ADR_W'(1);
        r_fetch_cnt <= r_fetch_cnt + LEN_W'(1);
      end
      if (w_pop) r_sent_cnt <= r_sent_cnt + LEN_W'(1);
      if (w_out_free) begin
        if (r_skd_vld) begin
          r_out_dat <= r_skd_dat;
          r_out_vld <= 1'b1;
          r_skd_vld <= r_rd_pend;
          if (r_rd_pend) r_skd_dat <= rd_dat_r;
        end else if (r_rd_pend) begin
          r_out_dat <= rd_dat_r;
          r_out_vld <= 1'b1;
        end else begin
          r_out_vld <= 1'b0;
        end
      end else if (r_rd_pend) begin
        r_skd_dat <= rd_dat_r;
        r_skd_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb2_ep_rd_stream.sv
// Scoreboard bench for usb2_ep_rd_stream: RAM model, expected-byte queue, negedge monitor.
`timescale 1ns/1ps
module tb_usb2_ep_rd_stream;
  localparam int LEN_W = 11;
  localparam int ADR_W = 10;
`ifdef USB2_EP_RD_CRC16_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  typedef logic [7:0] byte_q_t[$];

  logic             phy_clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [ADR_W-1:0] base_adr = '0, rd_adr;
  logic [LEN_W-1:0] length = '0;
  logic [7:0]       rd_dat_r, out_data;
  logic             out_valid, out_last, busy, done;

  usb2_ep_rd_stream #(.LEN_W(LEN_W), .ADR_W(ADR_W)) dut (
    .phy_clk(phy_clk), .reset_n(reset_n), .start(start), .base_adr(base_adr),
    .length(length), .abort(abort), .rd_adr(rd_adr), .rd_dat_r(rd_dat_r),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 phy_clk = ~phy_clk;

  // RAM with registered address, data valid the cycle after capture
  logic [7:0]       mem [0:1023];
  logic [ADR_W-1:0] ram_adr_q = '0;
  always @(posedge phy_clk) ram_adr_q <= rd_adr;
  assign rd_dat_r = mem[ram_adr_q];

  int cyc = 0;
  always @(posedge phy_clk) cyc <= cyc + 1;

  exp_t sbq[$];
  int   n_cmp = 0, n_err = 0;
  int   n_done, n_acc, n_valid, t_start, t_first, t_done, rdy_mode;
  bit   done_seen, first_seen;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crc16(input byte_q_t q);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i])
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ q[i][b]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return ~c;
  endfunction

  task automatic monitor();
    bit         stall_chk = 0, abort_prev = 0;
    logic [8:0] stall_val = '0;
    exp_t       e;
    forever begin
      @(negedge phy_clk);
      if (done) begin
        n_done++;
        if (!done_seen) begin done_seen = 1; t_done = cyc; end
      end
      if (out_valid) begin
        n_valid++;
        if (!first_seen) begin first_seen = 1; t_first = cyc; end
      end
      if (stall_chk && !abort_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {out_last, out_data}, stall_val);
      end
      stall_chk  = out_valid && !out_ready;
      stall_val  = {out_last, out_data};
      abort_prev = abort;
      if (out_valid && out_ready) begin
        n_acc++;
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_byte: got %0h expected none", out_data);
        end else begin
          e = sbq.pop_front();
          check("data", out_data, e.d);
          check("last", out_last, e.l);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge phy_clk); #1;
    out_ready = (rdy_mode == 1) ? 1'($urandom % 2) : (rdy_mode == 0);
  endtask

  task automatic clear_mon();
    n_done = 0; n_acc = 0; n_valid = 0; done_seen = 0; first_seen = 0;
  endtask

  task automatic load_exp(input int b, input int n);
    byte_q_t pay;
    logic [15:0] c;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      pay.push_back(mem[(b + i) % 1024]);
      e.d = pay[i]; e.l = (i == n - 1) && !CRC_EN;
      sbq.push_back(e);
    end
    if (CRC_EN) begin
      c = crc16(pay);
      e.d = c[7:0];  e.l = 1'b0; sbq.push_back(e);
      e.d = c[15:8]; e.l = 1'b1; sbq.push_back(e);
    end
  endtask

  task automatic issue(input int b, input int n);
    start = 1; base_adr = ADR_W'(b); length = LEN_W'(n); t_start = cyc;
  endtask

  task automatic run(input int b, input int n, input int mode, input bit chk_t, input bit inject);
    int budget = 40 + n * 8;
    load_exp(b, n);
    clear_mon();
    rdy_mode = mode;
    tick(); issue(b, n);
    tick(); start = 0;
    for (int k = 0; k < budget && !done_seen; k++) begin
      tick();
      if (inject && k == 10) begin start = 1; base_adr = 10'h200; length = 11'd5; end
      else start = 0;
    end
    start = 0;
    if (!done_seen) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: no done within %0d cycles (base %0h len %0d)", budget, b, n);
    end
    tick(); tick();
    check("done_pulses", n_done, 1);
    check("queue_left", sbq.size(), 0);
    check("busy_after", busy, 0);
    if (n == 0) check("zero_len_valid", n_valid, CRC_EN ? 2 : 0);
    if (chk_t) begin
      check("first_seen", first_seen, (n > 0) || CRC_EN);
      if (first_seen) check("first_lat", t_first - t_start, (n > 0) ? 3 : 2);
      check("done_lat", t_done - t_start, (n == 0) ? (CRC_EN ? 4 : 2) : n + (CRC_EN ? 5 : 3));
    end
    sbq.delete();
  endtask

  task automatic abort_test();
    bit hit = 0;
    load_exp(12'h180, 10);
    clear_mon();
    rdy_mode = 0;
    tick(); issue(12'h180, 10);
    tick(); start = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      tick();
      hit = (n_acc >= 3);
    end
    check("abort_reach3", hit, 1);
    rdy_mode = 2; out_ready = 0; abort = 1;
    tick(); abort = 0;
    check("abort_valid_drop", out_valid, 0);
    check("abort_accepted", n_acc, 3);
    tick(); tick(); tick();
    check("abort_done_pulses", n_done, 1);
    check("abort_busy", busy, 0);
    sbq.delete();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[16'h010] = 8'h11; mem[16'h011] = 8'h22; mem[16'h012] = 8'h33; mem[16'h013] = 8'h44;
    for (int i = 0; i < 9; i++) mem[16'h100 + i] = 8'h31 + 8'(i);
    rdy_mode = 0;
    clear_mon();
    fork monitor(); join_none
    tick(); tick();
    check("rst_rd_adr", rd_adr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1;
    tick(); tick();

    run(12'h010, 4, 0, 1, 0);        // basic
    run(12'h3FE, 4, 0, 1, 0);        // address wrap
    run(12'h080, 64, 1, 0, 1);       // backpressure + start while busy
    run(12'h050, 0, 0, 1, 0);        // zero length
    run(12'h100, 9, 0, 1, 0);        // "123456789"
    abort_test();
    run(12'h2A0, 6, 1, 0, 0);        // restart after abort

    clear_mon();                     // abort while idle
    tick(); abort = 1;
    tick(); abort = 0;
    tick(); tick();
    check("idle_abort_done", n_done, 0);
    check("idle_abort_busy", busy, 0);

    for (int r = 0; r < 4; r++)
      run(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)), 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
